// File: rtl/dac_pkg.sv
// Shared types and helpers for the multi-channel behavioural DAC model.
// Converts an unsigned code to a voltage and derives the reset code and
// channel-select width from the top-level parameters.
package dac_pkg;

   // Two-state settle sequencer.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } dac_state_t;

   // Widest converter the model supports; codes are carried at this width
   // through the helper functions.
   localparam int MAX_NBITS = 24;

   // Width of the settle counter; enough for a latency of 15 cycles.
   localparam int CNT_W = 4;

   // Channel-select width: $clog2(nch) but never narrower than one bit.
   function automatic int chw_of(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   // Code held by every register after reset: zero volts in either mode.
   // Unipolar zero volts is code 0; bipolar zero volts is mid-scale.
   function automatic logic [MAX_NBITS-1:0] rst_code_of(input int nbits, input bit bipolar);
      return bipolar ? (MAX_NBITS'(1) << (nbits - 1)) : '0;
   endfunction

   // Transfer function.
   // Unipolar: vref * code / 2^nbits.
   // Bipolar offset-binary: vref * (code - 2^(nbits-1)) / 2^(nbits-1).
   function automatic real code2volt(input logic [MAX_NBITS-1:0] code,
                                     input int nbits,
                                     input real vref,
                                     input bit bipolar);
      real full_scale;
      real mid_scale;
      real code_r;
      full_scale = real'(longint'(1) << nbits);
      mid_scale  = full_scale / 2.0;
      code_r     = real'(code);
      if (bipolar) begin
         return vref * (code_r - mid_scale) / mid_scale;
      end
      return vref * code_r / full_scale;
   endfunction

endpackage

// File: rtl/dac_chan_reg.sv
// One DAC channel: input register, DAC register and the settled
// code/analog output pair. The top-level sequencer decides when each
// register loads; this block only holds state.
module dac_chan_reg
   import dac_pkg::*;
#(
   parameter int  NBITS   = 12,
   parameter real VREF    = 5.0,
   parameter int  BIPOLAR = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_we,       // load input register from in_data
   input  logic [NBITS-1:0] in_data,
   input  logic             dac_we,      // capture DAC register
   input  logic             dac_sel_wr,  // capture from in_data instead of input register
   input  logic             commit,      // settle complete: publish DAC register
   output logic [NBITS-1:0] code_out,
   output real              a_out
);

   localparam logic [NBITS-1:0] RST_CODE = NBITS'(rst_code_of(NBITS, BIPOLAR != 0));

   logic [NBITS-1:0] in_q,   in_d;
   logic [NBITS-1:0] dac_q,  dac_d;
   logic [NBITS-1:0] code_q, code_d;
   real              a_q,    a_d;

   // Next-state for all four registers. The DAC register samples the old
   // input register so a write and an ldac on the same edge keep them apart.
   always_comb begin
      in_d   = in_q;
      dac_d  = dac_q;
      code_d = code_q;
      a_d    = a_q;
      if (in_we) begin
         in_d = in_data;
      end
      if (dac_we) begin
         dac_d = dac_sel_wr ? in_data : in_q;
      end
      if (commit) begin
         code_d = dac_q;
         a_d    = code2volt(MAX_NBITS'(dac_q), NBITS, VREF, BIPOLAR != 0);
      end
   end

   // Channel state flops; the analog output is 0.0 after reset in both modes.
   // NOTE: every flop here is a handful of discrete registers, not a memory
   // array, so all of them take the async reset; state uses <= only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q   <= RST_CODE;
         dac_q  <= RST_CODE;
         code_q <= RST_CODE;
         a_q    <= 0.0;
      end else begin
         in_q   <= in_d;
         dac_q  <= dac_d;
         code_q <= code_d;
         a_q    <= a_d;
      end
   end

   assign code_out = code_q;
   assign a_out    = a_q;

endmodule

// File: rtl/dac_model_mc.sv
// Multi-channel double-buffered virtual DAC. Writes land in per-channel
// input registers over a valid/ready handshake; an ldac strobe (or an
// auto-update write) captures the DAC registers and, LATENCY cycles later,
// the settled codes and analog voltages appear on code_out / a_out.
module dac_model_mc
   import dac_pkg::*;
#(
   parameter int  NBITS   = 12,
   parameter int  NCH     = 4,
   parameter real VREF    = 5.0,
   parameter int  LATENCY = 2,
   parameter int  BIPOLAR = 0,
   parameter int  CHW     = chw_of(NCH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [CHW-1:0]            wr_ch,
   input  logic [NBITS-1:0]          wr_data,
   input  logic                      ldac,
   input  logic                      auto_upd,
   output logic                      busy,
   output logic                      err,
   output logic [NCH-1:0][NBITS-1:0] code_out,
   output real                       a_out [NCH]
);

   // Counter starts at LATENCY-1 so the publish edge is LATENCY edges
   // after the update edge.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   dac_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             pend_q,  pend_d;
   logic             err_q,   err_d;

   logic idle;
   logic wr_acc;       // handshake completes this cycle
   logic ch_ok;        // target channel exists
   logic wr_hit;       // accepted write to a real channel
   logic wr_upd;       // accepted write that also updates its DAC register
   logic ldac_evt;     // fresh strobe or one deferred from SETTLE
   logic upd_start;    // update edge: capture DAC registers, begin settling
   logic settle_done;  // publish edge

   assign idle        = (state_q == IDLE);
   // NOTE: wr_ready is gated by rst_n combinationally so it is low for the
   // whole reset pulse, not just after the first clock edge.
   assign wr_ready    = rst_n & idle;
   assign wr_acc      = wr_valid & wr_ready;
   assign ch_ok       = (32'(wr_ch) < 32'(NCH));
   assign wr_hit      = wr_acc & ch_ok;
   assign wr_upd      = wr_hit & auto_upd;
   assign ldac_evt    = ldac | pend_q;
   assign upd_start   = idle & (ldac_evt | wr_upd);
   assign settle_done = (state_q == SETTLE) && (cnt_q == '0);

   // Sequencer next-state: launch on an update event, count down in SETTLE,
   // fold any ldac seen while settling into a single pending flag.
   // NOTE: every variable gets its hold value first so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      err_d   = err_q;
      if (wr_acc && !ch_ok) begin
         err_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (upd_start) begin
               state_d = SETTLE;
               cnt_d   = CNT_LOAD;
               pend_d  = 1'b0;
            end
         end
         SETTLE: begin
            if (ldac) begin
               pend_d = 1'b1;
            end
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer flops; reset abandons any settle in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q == SETTLE);
   assign err  = err_q;

   // One register slice per channel. On an ldac event every channel copies
   // its input register; an auto-update write overrides its own channel
   // with the incoming data. Channels not captured keep their DAC code.
   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic sel;
      logic in_we;
      logic dac_we;
      logic dac_sel_wr;

      assign sel        = (wr_ch == CHW'(k));
      assign in_we      = wr_hit & sel;
      assign dac_sel_wr = wr_upd & sel;
      assign dac_we     = upd_start & (ldac_evt | dac_sel_wr);

      dac_chan_reg #(
         .NBITS   (NBITS),
         .VREF    (VREF),
         .BIPOLAR (BIPOLAR)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_we      (in_we),
         .in_data    (wr_data),
         .dac_we     (dac_we),
         .dac_sel_wr (dac_sel_wr),
         .commit     (settle_done),
         .code_out   (code_out[k]),
         .a_out      (a_out[k])
      );
   end

endmodule

// File: tb/tb_dac_model_mc.sv
// Bench for dac_model_mc. Two instances run side by side:
//   inst 0: unipolar, 12 bits, 4 channels, latency 2
//   inst 1: bipolar,  12 bits, 5 channels, latency 3 (3-bit wr_ch allows
//           addressing the non-existent channels 5..7)
// A transaction-level model (remaining-settle-cycles counter per instance,
// plain arrays for the register contents) predicts every output; it is
// compared on every falling edge, plus directed spot checks.
module tb_dac_model_mc;

   localparam int NB    = 12;
   localparam int NCH_A = 4;
   localparam int NCH_B = 5;
   localparam int LAT_A = 2;
   localparam int LAT_B = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // Stimulus, indexed by instance.
   logic          wr_valid [2];
   logic [2:0]    wr_ch    [2];
   logic [NB-1:0] wr_data  [2];
   logic          ldac     [2];
   logic          auto_upd [2];

   // Outputs.
   logic                    ready_a, busy_a, err_a;
   logic                    ready_b, busy_b, err_b;
   logic [NCH_A-1:0][NB-1:0] code_a;
   logic [NCH_B-1:0][NB-1:0] code_b;
   real                     a_out_a [NCH_A];
   real                     a_out_b [NCH_B];

   dac_model_mc #(
      .NBITS(NB), .NCH(NCH_A), .VREF(5.0), .LATENCY(LAT_A), .BIPOLAR(0)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid[0]), .wr_ready(ready_a),
      .wr_ch(wr_ch[0][1:0]), .wr_data(wr_data[0]),
      .ldac(ldac[0]), .auto_upd(auto_upd[0]),
      .busy(busy_a), .err(err_a),
      .code_out(code_a), .a_out(a_out_a)
   );

   dac_model_mc #(
      .NBITS(NB), .NCH(NCH_B), .VREF(5.0), .LATENCY(LAT_B), .BIPOLAR(1)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid[1]), .wr_ready(ready_b),
      .wr_ch(wr_ch[1]), .wr_data(wr_data[1]),
      .ldac(ldac[1]), .auto_upd(auto_upd[1]),
      .busy(busy_b), .err(err_b),
      .code_out(code_b), .a_out(a_out_b)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nch_of(input int i);  return (i == 0) ? NCH_A : NCH_B; endfunction
   function automatic int lat_of(input int i);  return (i == 0) ? LAT_A : LAT_B; endfunction
   function automatic bit bip_of(input int i);  return (i == 1); endfunction
   function automatic int zero_code(input int i); return bip_of(i) ? 2048 : 0; endfunction

   int m_in   [2][5];
   int m_dac  [2][5];
   int m_code [2][5];
   int m_left [2];     // edges until the pending output change; 0 = idle
   bit m_pend [2];
   bit m_err  [2];
   bit m_acc  [2];     // write accepted on the last rising edge

   task automatic model_step(input int i);
      int ch;
      bit acc, hit, lev;
      ch  = int'(wr_ch[i]);
      acc = wr_valid[i] && (m_left[i] == 0);
      m_acc[i] = acc;
      if (m_left[i] != 0) begin
         if (ldac[i]) m_pend[i] = 1'b1;
         m_left[i]--;
         if (m_left[i] == 0)
            for (int c = 0; c < 5; c++) m_code[i][c] = m_dac[i][c];
      end else begin
         lev = ldac[i] || m_pend[i];
         hit = acc && (ch < nch_of(i));
         if (acc && !hit) m_err[i] = 1'b1;
         if (lev || (hit && auto_upd[i])) begin
            if (lev)
               for (int c = 0; c < 5; c++) m_dac[i][c] = m_in[i][c];
            if (hit && auto_upd[i]) m_dac[i][ch] = int'(wr_data[i]);
            m_left[i] = lat_of(i);
            m_pend[i] = 1'b0;
         end
         if (hit) m_in[i][ch] = int'(wr_data[i]);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 5; c++) begin
               m_in[i][c]   = zero_code(i);
               m_dac[i][c]  = zero_code(i);
               m_code[i][c] = zero_code(i);
            end
            m_left[i] = 0;
            m_pend[i] = 1'b0;
            m_err[i]  = 1'b0;
            m_acc[i]  = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   // Analog value expressed in LSBs of the transfer function, rounded.
   function automatic longint volt_lsb(input real v, input int i);
      real scale;
      scale = bip_of(i) ? (2048.0 / 5.0) : (4096.0 / 5.0);
      return longint'($floor(v * scale + 0.5));
   endfunction

   function automatic longint uv(input real v);
      return longint'($floor(v * 1.0e6 + 0.5));
   endfunction

   task automatic check_inst(input int i);
      longint code_obs;
      real    a_obs;
      check($sformatf("busy%0d", i),  longint'(i == 0 ? busy_a  : busy_b),  longint'(m_left[i] != 0));
      check($sformatf("ready%0d", i), longint'(i == 0 ? ready_a : ready_b), longint'(rst_n && m_left[i] == 0));
      check($sformatf("err%0d", i),   longint'(i == 0 ? err_a   : err_b),   longint'(m_err[i]));
      for (int c = 0; c < nch_of(i); c++) begin
         if (i == 0) begin
            code_obs = longint'(code_a[c]);
            a_obs    = a_out_a[c];
         end else begin
            code_obs = longint'(code_b[c]);
            a_obs    = a_out_b[c];
         end
         check($sformatf("code%0d[%0d]", i, c), code_obs, longint'(m_code[i][c]));
         check($sformatf("aout%0d[%0d]", i, c), volt_lsb(a_obs, i),
               longint'(m_code[i][c] - (bip_of(i) ? 2048 : 0)));
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check_inst(0);
         check_inst(1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_wr(input int i, input int ch, input int data, input bit au);
      wr_valid[i] = 1'b1;
      wr_ch[i]    = 3'(ch);
      wr_data[i]  = NB'(data);
      auto_upd[i] = au;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         wr_valid[i] = 1'b0; wr_ch[i] = '0; wr_data[i] = '0;
         ldac[i] = 1'b0; auto_upd[i] = 1'b0;
      end
      #1 rst_n = 1'b0;
      chk_on = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
      check("rst_code_b0", longint'(code_b[0]), 'h800);
      check("rst_aout_b0", uv(a_out_b[0]), 0);
      check("rst_aout_a0", uv(a_out_a[0]), 0);
      check("rst_busy_a", longint'(busy_a), 0);

      // 1: buffered write, no ldac -> no output change; ldac -> 2.5 V after 2 edges
      set_wr(0, 1, 'h800, 1'b0);
      tick();
      wr_valid[0] = 1'b0;
      tick(); tick();
      check("t1_busy_idle", longint'(busy_a), 0);
      check("t1_a1_hold", uv(a_out_a[1]), 0);
      ldac[0] = 1'b1;
      tick();
      ldac[0] = 1'b0;
      check("t1_busy_e0", longint'(busy_a), 1);
      check("t1_a1_e0", uv(a_out_a[1]), 0);
      tick();
      check("t1_busy_e1", longint'(busy_a), 1);
      check("t1_a1_e1", uv(a_out_a[1]), 0);
      tick();
      check("t1_busy_e2", longint'(busy_a), 0);
      check("t1_a1_e2", uv(a_out_a[1]), 2500000);
      check("t1_a0_e2", uv(a_out_a[0]), 0);
      check("t1_a3_e2", uv(a_out_a[3]), 0);

      // 2: auto-update write of full scale on ch3
      set_wr(0, 3, 'hFFF, 1'b1);
      tick();
      wr_valid[0] = 1'b0;
      check("t2_ready_e0", longint'(ready_a), 0);
      tick();
      check("t2_ready_e1", longint'(ready_a), 0);
      tick();
      check("t2_ready_e2", longint'(ready_a), 1);
      check("t2_a3", uv(a_out_a[3]), 4998779);
      check("t2_code3", longint'(code_a[3]), 'hFFF);

      // 3: ldac twice while settling, plus a write stalled by SETTLE
      ldac[0] = 1'b1;
      tick();                                  // launch
      set_wr(0, 0, 'h123, 1'b0);
      tick();                                  // ldac in SETTLE, write stalled
      check("t3_ready_stall", longint'(ready_a), 0);
      check("t3_busy_e1", longint'(busy_a), 1);
      tick();                                  // second ldac in SETTLE, settle ends
      ldac[0] = 1'b0;
      check("t3_busy_e2", longint'(busy_a), 0);
      check("t3_ready_e2", longint'(ready_a), 1);
      tick();                                  // pending launch, write accepted
      wr_valid[0] = 1'b0;
      check("t3_busy_extra", longint'(busy_a), 1);
      tick(); tick();
      check("t3_busy_done", longint'(busy_a), 0);
      check("t3_code0_old", longint'(code_a[0]), 0);
      tick();
      check("t3_busy_once", longint'(busy_a), 0);
      ldac[0] = 1'b1;
      tick();
      ldac[0] = 1'b0;
      tick(); tick();
      check("t3_code0_new", longint'(code_a[0]), 'h123);

      // 4: bipolar transfer function on inst 1 (latency 3)
      set_wr(1, 2, 'h000, 1'b1);
      tick();
      wr_valid[1] = 1'b0;
      tick(); tick(); tick();
      check("t4_neg_fs", uv(a_out_b[2]), -5000000);
      set_wr(1, 2, 'hC00, 1'b1);
      tick();
      wr_valid[1] = 1'b0;
      tick(); tick(); tick();
      check("t4_half", uv(a_out_b[2]), 2500000);

      // 5: write to a non-existent channel
      set_wr(1, 5, 'h111, 1'b1);
      tick();
      wr_valid[1] = 1'b0;
      check("t5_err", longint'(err_b), 1);
      check("t5_no_busy", longint'(busy_b), 0);
      tick();
      check("t5_a2_kept", uv(a_out_b[2]), 2500000);
      set_wr(1, 1, 'h900, 1'b1);
      tick();
      wr_valid[1] = 1'b0;
      tick(); tick(); tick();
      check("t5_err_sticky", longint'(err_b), 1);

      // 6: reset one cycle into SETTLE
      set_wr(0, 0, 'h400, 1'b1);
      tick();
      wr_valid[0] = 1'b0;
      check("t6_busy_pre", longint'(busy_a), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_busy_rst", longint'(busy_a), 0);
      check("t6_ready_rst", longint'(ready_a), 0);
      check("t6_a1_rst", uv(a_out_a[1]), 0);
      check("t6_a3_rst", uv(a_out_a[3]), 0);
      check("t6_err_clr", longint'(err_b), 0);
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 5; n++) begin
         tick();
         check("t6_no_busy", longint'(busy_a), 0);
         check("t6_a0_zero", uv(a_out_a[0]), 0);
      end

      // Randomised traffic on both instances; writes hold until accepted.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!(wr_valid[i] && !m_acc[i])) begin
               wr_valid[i] = ($urandom_range(0, 2) == 0);
               wr_ch[i]    = (i == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 5));
               wr_data[i]  = NB'($urandom);
               auto_upd[i] = 1'($urandom_range(0, 1));
            end
            ldac[i] = ($urandom_range(0, 9) == 0);
         end
         tick();
      end

      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
